// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: op codes, default widths and op classification.
package alu_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;

  function automatic logic is_shift(input logic [2:0] con);
    return (con == ALU_SHL) || (con == ALU_SHR);
  endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_select.sv
// Per-source forwarding mux and hazard detect; combinational, no state.
// Priority: advancing held entry, then non-load MEM, then WB, then register file.
module fwd_select
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] src_idx_i,
  input  logic          src_used_i,
  input  logic [DW-1:0] rf_val_i,
  input  logic          ex_vld_i,
  input  logic          ex_wr_en_i,
  input  logic          ex_is_load_i,
  input  logic          ex_adv_i,
  input  logic [RW-1:0] ex_rd_idx_i,
  input  logic [DW-1:0] ex_data_i,
  input  logic          mem_wr_en_i,
  input  logic          mem_is_load_i,
  input  logic [RW-1:0] mem_rd_idx_i,
  input  logic [DW-1:0] mem_data_i,
  input  logic          wb_wr_en_i,
  input  logic [RW-1:0] wb_rd_idx_i,
  input  logic [DW-1:0] wb_data_i,
  output logic [DW-1:0] val_o,
  output logic          haz_o
);

  logic src_nz;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // r0 is hard-wired zero, so it never matches any producer.
  assign src_nz  = (src_idx_i != '0);
  assign ex_hit  = src_nz & ex_vld_i & ex_wr_en_i & (ex_rd_idx_i == src_idx_i);
  assign mem_hit = src_nz & mem_wr_en_i & (mem_rd_idx_i == src_idx_i);
  assign wb_hit  = src_nz & wb_wr_en_i & (wb_rd_idx_i == src_idx_i);

  assign haz_o = src_used_i &
                 ((ex_hit & (ex_is_load_i | ~ex_adv_i)) | (mem_hit & mem_is_load_i));

  always_comb begin
    val_o = rf_val_i;
    if (ex_hit & ex_adv_i) begin
      val_o = ex_data_i;
    end else if (mem_hit & ~mem_is_load_i) begin
      val_o = mem_data_i;
    end else if (wb_hit) begin
      val_o = wb_data_i;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-ALU pipeline register with operand forwarding; 1-cycle accept-to-ALU latency.
// Holds its entry while out_ready is low; stalls decode on load-use and blocked producers.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_con,
  input  logic [RW-1:0] in_rs_idx,
  input  logic [RW-1:0] in_rt_idx,
  input  logic [DW-1:0] in_rs_val,
  input  logic [DW-1:0] in_rt_val,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  input  logic [4:0]    in_sft_amt,
  input  logic [RW-1:0] in_rd_idx,
  input  logic          in_wr_en,
  input  logic          in_is_load,
  input  logic [DW-1:0] alu_result,
  input  logic          mem_wr_en,
  input  logic [RW-1:0] mem_rd_idx,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_is_load,
  input  logic          wb_wr_en,
  input  logic [RW-1:0] wb_rd_idx,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    alu_con,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [4:0]    alu_sft_amt,
  output logic [RW-1:0] out_rd_idx,
  output logic          out_wr_en,
  output logic          out_is_load,
  output logic [CW-1:0] stall_cnt
);

  logic          valid_q, valid_d;
  logic [2:0]    con_q, con_d;
  logic [DW-1:0] op1_q, op1_d;
  logic [DW-1:0] op2_q, op2_d;
  logic [4:0]    sft_q, sft_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          ld_q, ld_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          advance;
  logic          shift_op;
  logic          rs_used, rt_used;
  logic          rs_haz, rt_haz, hazard;
  logic [DW-1:0] rs_fwd, rt_fwd;
  logic          accept;

  assign advance  = valid_q & out_ready;
  assign shift_op = is_shift(in_con);
  assign rs_used  = ~shift_op;
  assign rt_used  = shift_op | ~in_use_imm;

  fwd_select #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_idx_i    (in_rs_idx),
    .src_used_i   (rs_used),
    .rf_val_i     (in_rs_val),
    .ex_vld_i     (valid_q),
    .ex_wr_en_i   (wr_q),
    .ex_is_load_i (ld_q),
    .ex_adv_i     (advance),
    .ex_rd_idx_i  (rd_q),
    .ex_data_i    (alu_result),
    .mem_wr_en_i  (mem_wr_en),
    .mem_is_load_i(mem_is_load),
    .mem_rd_idx_i (mem_rd_idx),
    .mem_data_i   (mem_data),
    .wb_wr_en_i   (wb_wr_en),
    .wb_rd_idx_i  (wb_rd_idx),
    .wb_data_i    (wb_data),
    .val_o        (rs_fwd),
    .haz_o        (rs_haz)
  );

  fwd_select #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_idx_i    (in_rt_idx),
    .src_used_i   (rt_used),
    .rf_val_i     (in_rt_val),
    .ex_vld_i     (valid_q),
    .ex_wr_en_i   (wr_q),
    .ex_is_load_i (ld_q),
    .ex_adv_i     (advance),
    .ex_rd_idx_i  (rd_q),
    .ex_data_i    (alu_result),
    .mem_wr_en_i  (mem_wr_en),
    .mem_is_load_i(mem_is_load),
    .mem_rd_idx_i (mem_rd_idx),
    .mem_data_i   (mem_data),
    .wb_wr_en_i   (wb_wr_en),
    .wb_rd_idx_i  (wb_rd_idx),
    .wb_data_i    (wb_data),
    .val_o        (rt_fwd),
    .haz_o        (rt_haz)
  );

  assign hazard   = rs_haz | rt_haz;
  assign in_ready = (~valid_q | out_ready) & ~hazard & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    con_d   = con_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sft_d   = sft_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      con_d   = in_con;
      rd_d    = in_rd_idx;
      wr_d    = in_wr_en;
      ld_d    = in_is_load;
      if (shift_op) begin
        op1_d = rt_fwd;
        op2_d = '0;
        sft_d = in_sft_amt;
      end else begin
        op1_d = rs_fwd;
        op2_d = in_use_imm ? in_imm : rt_fwd;
        sft_d = '0;
      end
    end else if (advance) begin
      valid_d = 1'b0;
    end
    // Saturating: stops at all-ones rather than wrapping.
    if (in_valid & hazard & ~flush & ~(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      con_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sft_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      ld_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      con_q   <= con_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sft_q   <= sft_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_con     = con_q;
  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign alu_sft_amt = sft_q;
  assign out_rd_idx  = rd_q;
  assign out_wr_en   = wr_q;
  assign out_is_load = ld_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the ALU and drives its con, op1, op2 and sft_amt inputs from a registered, valid/ready-qualified entry.
- Resolves operand forwarding from the EX, MEM and WB stages at capture time.
- Detects load-use and blocked-producer hazards and stalls decode for them.
- Holds its entry under downstream backpressure and honours flush.

Parameters:
- DW, 32, datapath width; must equal the ALU operand width.
- RW, 5, register index width.
- CW, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard held entry and any same-cycle accept.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle (combinational).
- in_con  in  3  ALU op code: 1 add, 2 sub, 3 and, 4 or, 5 shl, 6 shr, others give result 0.
- in_rs_idx, in_rt_idx  in  RW  source register indices.
- in_rs_val, in_rt_val  in  DW  register-file read values; index 0 reads 0.
- in_imm  in  DW  sign/zero-extended immediate.
- in_use_imm  in  1  op2 comes from in_imm.
- in_sft_amt  in  5  shift amount.
- in_rd_idx  in  RW  destination index.
- in_wr_en  in  1  instruction writes rd.
- in_is_load  in  1  instruction is a load; its ALU result is an address.
- alu_result  in  DW  combinational ALU output for the held entry.
- mem_wr_en, mem_rd_idx, mem_data, mem_is_load  in  1/RW/DW/1  MEM-stage producer.
- wb_wr_en, wb_rd_idx, wb_data  in  1/RW/DW  WB-stage producer.
- out_valid  out  1  held entry is valid.
- out_ready  in  1  downstream (EX/MEM register) takes the entry.
- alu_con  out  3  registered op code.
- alu_op1, alu_op2  out  DW  registered operands.
- alu_sft_amt  out  5  registered shift amount.
- out_rd_idx, out_wr_en, out_is_load  out  RW/1/1  carried to the downstream stage.
- stall_cnt  out  CW  count of hazard-stall cycles; saturates at all-ones.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0; all alu_* and out_* outputs=0; stall_cnt=0. While rst=1, in_ready=0.
- Source usage rules:
  - Shifts (con 5/6) use rt only.
  - All other ops use rs, and use rt when in_use_imm=0.
  - Index 0 is never a hazard and is never forwarded.
- advance = out_valid & out_ready.
- Hazard is asserted when any used source s (nonzero) matches one of:
  - The held entry (out_valid, out_wr_en, out_rd_idx==s) and either out_is_load=1 or advance=0.
  - The MEM producer (mem_wr_en, mem_rd_idx==s) and mem_is_load=1.
- in_ready = (~out_valid | out_ready) & ~hazard & ~rst. Accept = in_valid & in_ready.
- Forwarded value for source s, highest priority first:
  - alu_result, when the held entry matches s and is advancing.
  - mem_data, when the MEM producer matches s (non-load).
  - wb_data, when the WB producer matches s.
  - Otherwise the register-file value.
- Capture on Accept & ~flush: alu_con=in_con; out_rd_idx/out_wr_en/out_is_load latch their inputs; out_valid=1. Operand mapping:
  - Shift: op1=fwd(rt), op2=0, sft_amt=in_sft_amt.
  - Else: op1=fwd(rs); op2=in_use_imm ? in_imm : fwd(rt); sft_amt=0.
- No accept and advance: out_valid=0; data fields hold their last values.
- No accept and no advance: entry held unchanged. Operands latched at capture stay correct because all producers are older.
- flush=1: out_valid=0 at the next edge regardless of Accept or advance. A same-cycle accept is dropped. in_ready still reflects the formula.
- stall_cnt increments by 1 on each cycle with in_valid & hazard & ~flush. It holds at 2^CW-1.
- Latency: 1 cycle from accept to ALU inputs. Throughput: 1 per cycle with no hazards and out_ready=1.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op-code constants (ALU_ADD=1 ... ALU_SHR=6).
  - DW and RW defaults.
  - An is_shift helper.
- One natural sub-module, fwd_select: a combinational priority mux for a single source, instantiated twice (rs and rt).

Test Plan:
- Back-to-back dependence: add r3=r1+r2 (r1=5, r2=7), then sub r4=r3-r1 with out_ready=1 -> second entry has alu_op1=12 from alu_result, alu_op2=5; no stall; stall_cnt=0.
- Load-use: held entry is a load to r8, next instruction uses r8 -> in_ready=0 for one cycle and stall_cnt=1. Then the load sits in MEM with mem_is_load=1, so the stall continues: stall_cnt=2. Then the WB value 0xDEAD_BEEF is forwarded into alu_op1.
- Shift: con=5, rt=r2=0x1, sft_amt=4 -> alu_op1=0x1, alu_op2=0, alu_sft_amt=4, alu_con=5.
- Backpressure: out_ready=0 for 3 cycles with a valid entry -> outputs stable, in_ready=0. A dependent instruction does not count toward stall_cnt until it presents in_valid.
- Flush with simultaneous accept -> out_valid=0 at the next edge; the next accept captures normally.
- Reset mid-operation (out_valid=1, stall_cnt=9) -> at the next edge all outputs are 0 and in_ready=0 while rst=1. Index-0 check: a source index of 0 never stalls, even while the WB producer writes index 0.
